// File: rtl/ela_mem_arbiter.sv
// ela_mem_arbiter: shares the single-port ELA result memory between the engine
// write stream and host readback.
// Engine writes are buffered in a small FIFO and drained one per cycle. Host reads
// take three cycles of port time. Frame completion is reported once the last
// engine write has been issued to memory.
// Build option: define ELA_ARB_HOST_PRIO_EN for strict host priority. A full FIFO
// still gets one write through. Without it, bounded-burst fairness is used.
module ela_mem_arbiter #(
    parameter int unsigned AW         = 13,
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eng_valid,
    output logic          eng_ready,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_data,
    input  logic          eng_done,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wr,
    input  logic [DW-1:0] mem_rd,
    output logic          frame_done
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StArb,
        StRdIssue,
        StRdCap
    } state_e;

    // Write FIFO
    logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    // Arbiter / memory port
    state_e           state_q, state_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_wen_q, mem_wen_d;
    logic [DW-1:0]    mem_wr_q, mem_wr_d;
    logic             host_ack_q, host_ack_d;
    logic [DW-1:0]    host_rdata_q, host_rdata_d;
    logic             host_pend;
    logic             grant_wr;
    logic             grant_rd;

    // Frame completion
    logic             pend_q, pend_d;
    logic             frame_done_q, frame_done_d;

`ifdef ELA_ARB_HOST_PRIO_EN
    // Set after the single write let through a full FIFO while the host waits.
    logic             forced_q, forced_d;
`else
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
    logic [BurstW-1:0] burst_q, burst_d;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntFull);
    assign eng_ready  = !fifo_full;
    assign push       = eng_valid && !fifo_full;
    assign pop        = grant_wr;
    assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

    // The request is ignored during the ack cycle so a held request is not read twice.
    assign host_pend = host_req && !host_ack_q;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {eng_addr, eng_data};
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbitration: pick at most one of write/read in the ARB state.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == StArb) begin
`ifdef ELA_ARB_HOST_PRIO_EN
            if (host_pend && fifo_full && !forced_q) begin
                grant_wr = 1'b1;
            end else if (host_pend) begin
                grant_rd = 1'b1;
            end else if (!fifo_empty) begin
                grant_wr = 1'b1;
            end
`else
            if (host_pend && !fifo_empty) begin
                if (burst_q < BurstMax) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else if (host_pend) begin
                grant_rd = 1'b1;
            end else if (!fifo_empty) begin
                grant_wr = 1'b1;
            end
`endif
        end
    end

`ifdef ELA_ARB_HOST_PRIO_EN
    // Forced-write flag: one write per full-FIFO episode, then the host goes first.
    always_comb begin
        forced_d = forced_q;
        if (!host_pend || grant_rd) begin
            forced_d = 1'b0;
        end else if (grant_wr) begin
            forced_d = 1'b1;
        end
    end
`else
    // Burst counter: writes granted while the host waits, saturating at MAX_BURST.
    always_comb begin
        burst_d = burst_q;
        if (!host_pend || grant_rd) begin
            burst_d = '0;
        end else if (grant_wr && (burst_q != BurstMax)) begin
            burst_d = burst_q + BurstW'(1);
        end
    end
`endif

    // FSM next-state and registered memory/host port values.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = 1'b0;
        mem_wr_d     = mem_wr_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            StArb: begin
                if (grant_wr) begin
                    mem_wen_d  = 1'b1;
                    mem_addr_d = head_addr;
                    mem_wr_d   = head_data;
                end else if (grant_rd) begin
                    mem_addr_d = host_addr;
                    state_d    = StRdIssue;
                end
            end
            StRdIssue: begin
                // Memory samples the read address at the end of this cycle.
                state_d = StRdCap;
            end
            StRdCap: begin
                host_rdata_d = mem_rd;
                host_ack_d   = 1'b1;
                state_d      = StArb;
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    // Frame-done tracking: wait for the FIFO to drain and no write to be issuing.
    always_comb begin
        pend_d       = pend_q;
        frame_done_d = frame_done_q;
        if (push) begin
            frame_done_d = 1'b0;
        end
        if (pend_q && fifo_empty && !mem_wen_d && !push) begin
            frame_done_d = 1'b1;
            pend_d       = 1'b0;
        end
        if (eng_done) begin
            pend_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= StArb;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wr_q     <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef ELA_ARB_HOST_PRIO_EN
            forced_q     <= 1'b0;
`else
            burst_q      <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wr_q     <= mem_wr_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            pend_q       <= pend_d;
            frame_done_q <= frame_done_d;
`ifdef ELA_ARB_HOST_PRIO_EN
            forced_q     <= forced_d;
`else
            burst_q      <= burst_d;
`endif
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wr     = mem_wr_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ela_mem_arbiter.sv
// Self-checking bench for ela_mem_arbiter with a behavioural 8Kx8 synchronous memory.
// Engine writes and host reads are checked through expected-value queues.
module tb_ela_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
`ifdef ELA_ARB_HOST_PRIO_EN
    localparam int AckCyc = 3;
`else
    localparam int AckCyc = 11;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          eng_valid;
    logic          eng_ready;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_data;
    logic          eng_done;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wr;
    logic [DW-1:0] mem_rd;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    int accepted = 0;

    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    exp_rd [$];
    logic [AW+DW-1:0] wr_e;
    logic [DW-1:0]    rd_e;
    logic [DW-1:0]    mem [0:8191];

    ela_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .FIFO_DEPTH(4),
        .MAX_BURST(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eng_valid(eng_valid),
        .eng_ready(eng_ready),
        .eng_addr(eng_addr),
        .eng_data(eng_data),
        .eng_done(eng_done),
        .host_req(host_req),
        .host_addr(host_addr),
        .host_ack(host_ack),
        .host_rdata(host_rdata),
        .mem_addr(mem_addr),
        .mem_wen(mem_wen),
        .mem_wr(mem_wr),
        .mem_rd(mem_rd),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wr;
        mem_rd <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record every accepted engine write as an expected memory write.
    always @(posedge clk) begin
        if (!rst && eng_valid && eng_ready) begin
            exp_wr.push_back({eng_addr, eng_data});
            accepted++;
        end
    end

    // Memory write monitor: writes must appear in push order with matching addr/data.
    always @(negedge clk) begin
        if (!rst && mem_wen) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(mem_addr), 32'hffff_ffff);
            end else begin
                wr_e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(wr_e[AW+DW-1:DW]));
                check("wr_data", 32'(mem_wr), 32'(wr_e[DW-1:0]));
            end
        end
    end

    // Host ack monitor.
    always @(negedge clk) begin
        if (!rst && host_ack) begin
            acks++;
            if (exp_rd.size() == 0) begin
                check("ack_unexpected", 32'(host_rdata), 32'hffff_ffff);
            end else begin
                rd_e = exp_rd.pop_front();
                check("host_rdata", 32'(host_rdata), 32'(rd_e));
            end
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_wr.size() == 0 && !mem_wen) break;
            drive_pt();
        end
        check("drain", 32'(exp_wr.size()), 32'd0);
        drive_pt();
        drive_pt();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_host_ack"}, 32'(host_ack), 32'd0);
        check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_eng_ready"}, 32'(eng_ready), 32'd1);
    endtask

    function automatic logic exp_wen(input int c);
`ifdef ELA_ARB_HOST_PRIO_EN
        return !(c >= 1 && c <= 3);
`else
        return !(c >= 9 && c <= 11);
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_before;
        int base;
        rst       = 1'b0;
        eng_valid = 1'b0;
        eng_addr  = '0;
        eng_data  = '0;
        eng_done  = 1'b0;
        host_req  = 1'b0;
        host_addr = '0;
        #1 rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        drive_pt();
        rst = 1'b0;
        drive_pt();

        // Engine only: 6 back-to-back writes, mem_wen on cycles 2..7
        for (int c = 0; c <= 8; c++) begin
            eng_valid = (c < 6);
            eng_addr  = AW'(c);
            eng_data  = DW'(8'h10 + c);
            @(negedge clk);
            if (c < 6) check("eng_ready_stream", 32'(eng_ready), 32'd1);
            if (c >= 2 && c <= 7) check("wr_stream_wen", 32'(mem_wen), 32'd1);
            if (c == 8) check("wr_stream_end", 32'(mem_wen), 32'd0);
            drive_pt();
        end
        wait_drain();

        // Host only: preload 0x0105 = 0xA7, then read it back
        eng_valid = 1'b1;
        eng_addr  = 13'h0105;
        eng_data  = 8'hA7;
        drive_pt();
        eng_valid = 1'b0;
        wait_drain();
        acks_before = acks;
        host_req  = 1'b1;
        host_addr = 13'h0105;
        exp_rd.push_back(8'hA7);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check("host_ack_cycle", 32'(host_ack), 32'(c == 3));
            drive_pt();
            if (c == 3) host_req = 1'b0;
        end
        check("host_ack_count", 32'(acks - acks_before), 32'd1);
        drive_pt();
        check("host_rdata_hold", 32'(host_rdata), 32'hA7);

        // Contention: continuous engine feed, host request raised at cycle 0
        acks_before = acks;
        base = accepted;
        for (int c = -2; c <= 16; c++) begin
            eng_valid = (c <= 13);
            eng_addr  = AW'(13'h40 + (accepted - base));
            eng_data  = DW'((accepted - base) ^ 8'h5A);
            if (c == 0) begin
                host_req  = 1'b1;
                host_addr = 13'h0105;
                exp_rd.push_back(8'hA7);
            end
            if (c == AckCyc + 1) host_req = 1'b0;
            @(negedge clk);
            if (c >= 1) check("contention_wen", 32'(mem_wen), 32'(exp_wen(c)));
            if (c >= 0) check("contention_ack", 32'(host_ack), 32'(c == AckCyc));
            drive_pt();
        end
        eng_valid = 1'b0;
        wait_drain();
        check("contention_ack_count", 32'(acks - acks_before), 32'd1);

        // Frame done: eng_done with the last of 3 pushes, cleared by the next push
        for (int c = 0; c <= 9; c++) begin
            eng_valid = (c <= 2) || (c == 8);
            eng_addr  = AW'(13'h200 + c);
            eng_data  = DW'(8'hC0 + c);
            eng_done  = (c == 2);
            @(negedge clk);
            if (c == 4) check("frame_last_wen", 32'(mem_wen), 32'd1);
            check("frame_done", 32'(frame_done), 32'(c >= 5 && c <= 8));
            drive_pt();
        end
        eng_valid = 1'b0;
        eng_done  = 1'b0;
        wait_drain();

        // Reset mid-read: pushed writes and the read are discarded, no ack afterwards
        acks_before = acks;
        host_req  = 1'b1;
        host_addr = 13'h0003;
        exp_rd.push_back(8'h13);
        drive_pt();
        eng_valid = 1'b1;
        eng_addr  = 13'h0300;
        eng_data  = 8'h33;
        drive_pt();
        rst       = 1'b1;
        eng_valid = 1'b0;
        host_req  = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        #1;
        check_reset_vals("midreset");
        drive_pt();
        drive_pt();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_reset_ack", 32'(host_ack), 32'd0);
            check("post_reset_wen", 32'(mem_wen), 32'd0);
            drive_pt();
        end
        check("post_reset_ack_count", 32'(acks - acks_before), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
